// File: rtl/instr_encoder_loader.sv
// Encodes symbolic RV32I instruction fields into machine words and streams them
// into instruction memory, one word per accepted transfer, until END or capacity.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLT  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SLLI = 4'd4,
        OP_SLTI = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_BEQ  = 4'd8,
        OP_BNE  = 4'd9,
        OP_JAL  = 4'd10,
        OP_END  = 4'd15
    } op_t;

    localparam logic [6:0]        OPC_R     = 7'h33;
    localparam logic [6:0]        OPC_I     = 7'h13;
    localparam logic [6:0]        OPC_LOAD  = 7'h03;
    localparam logic [6:0]        OPC_STORE = 7'h23;
    localparam logic [6:0]        OPC_BR    = 7'h63;
    localparam logic [6:0]        OPC_JAL   = 7'h6F;
    localparam logic [31:0]       HALT_WORD = 32'h0000_006F;
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state;
    logic [ADDR_W-1:0] ptr;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        is_end;
    logic        fits_i;
    logic        fits_sh;
    logic        fits_b;
    logic        fits_j;
    logic        at_last_slot;

    // Immediate range checks: the upper bits must be a pure sign extension.
    assign fits_i       = (in_imm[31:11] == {21{in_imm[11]}});
    assign fits_sh      = (in_imm[31:5] == 27'd0);
    assign fits_b       = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
    assign fits_j       = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
    assign is_end       = (in_op == OP_END);
    assign at_last_slot = (word_count == LAST_SLOT);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        enc_word = 32'd0;
        enc_ok   = 1'b0;
        case (in_op)
            OP_ADD: begin
                enc_word = {7'h00, in_rs2, in_rs1, 3'd0, in_rd, OPC_R};
                enc_ok   = 1'b1;
            end
            OP_SUB: begin
                enc_word = {7'h20, in_rs2, in_rs1, 3'd0, in_rd, OPC_R};
                enc_ok   = 1'b1;
            end
            OP_SLT: begin
                enc_word = {7'h00, in_rs2, in_rs1, 3'd2, in_rd, OPC_R};
                enc_ok   = 1'b1;
            end
            OP_ADDI: begin
                enc_word = {in_imm[11:0], in_rs1, 3'd0, in_rd, OPC_I};
                enc_ok   = fits_i;
            end
            OP_SLTI: begin
                enc_word = {in_imm[11:0], in_rs1, 3'd2, in_rd, OPC_I};
                enc_ok   = fits_i;
            end
            OP_SLLI: begin
                enc_word = {7'h00, in_imm[4:0], in_rs1, 3'd1, in_rd, OPC_I};
                enc_ok   = fits_sh;
            end
            OP_LW: begin
                enc_word = {in_imm[11:0], in_rs1, 3'd2, in_rd, OPC_LOAD};
                enc_ok   = fits_i;
            end
            OP_SW: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'd2, in_imm[4:0], OPC_STORE};
                enc_ok   = fits_i;
            end
            OP_BEQ: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'd0,
                            in_imm[4:1], in_imm[11], OPC_BR};
                enc_ok   = fits_b;
            end
            OP_BNE: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'd1,
                            in_imm[4:1], in_imm[11], OPC_BR};
                enc_ok   = fits_b;
            end
            OP_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, OPC_JAL};
                enc_ok   = fits_j;
            end
            OP_END: begin
                enc_word = HALT_WORD;
                enc_ok   = 1'b1;
            end
            default: begin
                enc_word = 32'd0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= BASE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                // Restart from any state; a transfer offered this cycle is discarded.
                state      <= LOAD;
                ptr        <= BASE;
                imem_addr  <= BASE;
                in_ready   <= 1'b1;
                busy       <= 1'b1;
                done       <= 1'b0;
                err        <= 1'b0;
                word_count <= '0;
            end else if (state == LOAD && in_valid && in_ready) begin
                // The final slot is reserved for the halt word.
                if (enc_ok && (!at_last_slot || is_end)) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc_word;
                    word_count <= word_count + 1'b1;
                    if (!at_last_slot) begin
                        ptr <= ptr + 1'b1;
                    end
                    if (is_end) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        if (at_last_slot) begin
                            err <= 1'b1;
                        end
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: encodings, drops, capacity, restart and reset,
// using a default-size instance and a four-word instance.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst;

    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  word_count;

    logic        s_start;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [3:0]  s_in_op;
    logic [4:0]  s_in_rd;
    logic [4:0]  s_in_rs1;
    logic [4:0]  s_in_rs2;
    logic [31:0] s_in_imm;
    logic        s_imem_we;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic        s_busy;
    logic        s_done;
    logic        s_err;
    logic [2:0]  s_word_count;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_op(s_in_op), .in_rd(s_in_rd), .in_rs1(s_in_rs1), .in_rs2(s_in_rs2), .in_imm(s_in_imm),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .busy(s_busy), .done(s_done), .err(s_err), .word_count(s_word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one transfer to the large instance; checks the write one cycle later.
    task automatic xfer(input string tag, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic exp_we, input logic [7:0] exp_addr,
                        input logic [31:0] exp_data);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_we"}, {31'd0, imem_we}, {31'd0, exp_we});
        if (exp_we) begin
            check({tag, "_addr"}, {24'd0, imem_addr}, {24'd0, exp_addr});
            check({tag, "_data"}, imem_wdata, exp_data);
        end
    endtask

    task automatic xfer_s(input string tag, input logic [3:0] op, input logic [31:0] imm,
                          input logic exp_we, input logic [1:0] exp_addr,
                          input logic [31:0] exp_data);
        s_in_valid = 1'b1;
        s_in_op    = op;
        s_in_rd    = 5'd1;
        s_in_rs1   = 5'd0;
        s_in_rs2   = 5'd0;
        s_in_imm   = imm;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        check({tag, "_we"}, {31'd0, s_imem_we}, {31'd0, exp_we});
        if (exp_we) begin
            check({tag, "_addr"}, {30'd0, s_imem_addr}, {30'd0, exp_addr});
            check({tag, "_data"}, s_imem_wdata, exp_data);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_rd      = 5'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_imm     = 32'd0;
        s_start    = 1'b0;
        s_in_valid = 1'b0;
        s_in_op    = 4'd0;
        s_in_rd    = 5'd0;
        s_in_rs1   = 5'd0;
        s_in_rs2   = 5'd0;
        s_in_imm   = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", {23'd0, word_count}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Transfers offered while idle are ignored.
        xfer("idle_ignored", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 8'd0, 32'd0);

        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, in_ready}, 32'd1);

        xfer("addi", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 8'd0, 32'h0050_0093);
        xfer("add", 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 8'd1, 32'h0020_81B3);
        check("count2", {23'd0, word_count}, 32'd2);
        xfer("sub", 4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 8'd2, 32'h4020_81B3);
        xfer("lw", 4'd6, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b1, 8'd3, 32'hFFC1_2283);
        xfer("sw", 4'd7, 5'd9, 5'd1, 5'd2, 32'd8, 1'b1, 8'd4, 32'h0020_A423);

        xfer("drop_addi2048", 4'd3, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 8'd0, 32'd0);
        check("drop_err", {31'd0, err}, 32'd1);
        xfer("drop_beq_odd", 4'd8, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 8'd0, 32'd0);
        xfer("drop_illegal", 4'd11, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 8'd0, 32'd0);
        xfer("drop_slli32", 4'd4, 5'd2, 5'd1, 5'd0, 32'd32, 1'b0, 8'd0, 32'd0);
        xfer("drop_jal_big", 4'd10, 5'd1, 5'd0, 5'd0, 32'd1048576, 1'b0, 8'd0, 32'd0);
        check("drop_count", {23'd0, word_count}, 32'd5);
        check("drop_busy", {31'd0, busy}, 32'd1);

        xfer("after_drop", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 8'd5, 32'h0050_0093);
        xfer("slli31", 4'd4, 5'd2, 5'd1, 5'd7, 32'd31, 1'b1, 8'd6, 32'h01F0_9113);
        xfer("slt", 4'd2, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 8'd7, 32'h0020_A1B3);
        xfer("slti_m1", 4'd5, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 8'd8, 32'hFFF0_2093);
        xfer("bne_4094", 4'd9, 5'd0, 5'd1, 5'd2, 32'd4094, 1'b1, 8'd9, 32'h7E20_9FE3);
        xfer("addi_m2048", 4'd3, 5'd0, 5'd0, 5'd0, -32'sd2048, 1'b1, 8'd10, 32'h8000_0013);
        xfer("jal_min", 4'd10, 5'd0, 5'd0, 5'd0, -32'sd1048576, 1'b1, 8'd11, 32'h8000_006F);
        xfer("beq_m8", 4'd8, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 8'd12, 32'hFE20_8CE3);
        xfer("jal_16", 4'd10, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 8'd13, 32'h0100_00EF);
        xfer("end", 4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 8'd14, 32'h0000_006F);
        check("end_done", {31'd0, done}, 32'd1);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_ready", {31'd0, in_ready}, 32'd0);
        check("end_count", {23'd0, word_count}, 32'd15);

        xfer("done_ignored", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 8'd0, 32'd0);
        check("done_sticky", {31'd0, done}, 32'd1);

        // Restart from DONE, then restart mid-load with a transfer offered.
        pulse_start();
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_err", {31'd0, err}, 32'd0);
        check("restart_count", {23'd0, word_count}, 32'd0);
        xfer("rl_addi0", 4'd3, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 8'd0, 32'h0010_0093);
        xfer("rl_addi1", 4'd3, 5'd1, 5'd0, 5'd0, 32'd2, 1'b1, 8'd1, 32'h0020_0093);
        xfer("rl_drop", 4'd3, 5'd1, 5'd0, 5'd0, -32'sd2049, 1'b0, 8'd0, 32'd0);
        check("rl_err", {31'd0, err}, 32'd1);
        start    = 1'b1;
        xfer("mid_start", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 8'd0, 32'd0);
        start    = 1'b0;
        check("mid_count", {23'd0, word_count}, 32'd0);
        check("mid_err", {31'd0, err}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd1);
        xfer("mid_first", 4'd3, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 8'd0, 32'h0050_0093);

        // Four-word instance: the last slot only takes END.
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        xfer_s("cap0", 4'd3, 32'd1, 1'b1, 2'd0, 32'h0010_0093);
        xfer_s("cap1", 4'd3, 32'd2, 1'b1, 2'd1, 32'h0020_0093);
        xfer_s("cap2", 4'd3, 32'd3, 1'b1, 2'd2, 32'h0030_0093);
        xfer_s("cap3_drop", 4'd3, 32'd4, 1'b0, 2'd0, 32'd0);
        check("cap_err", {31'd0, s_err}, 32'd1);
        check("cap_busy", {31'd0, s_busy}, 32'd1);
        check("cap_count", {29'd0, s_word_count}, 32'd3);
        xfer_s("cap_end", 4'd15, 32'd0, 1'b1, 2'd3, 32'h0000_006F);
        check("cap_done", {31'd0, s_done}, 32'd1);
        check("cap_busy_end", {31'd0, s_busy}, 32'd0);
        check("cap_err_end", {31'd0, s_err}, 32'd1);
        check("cap_count_end", {29'd0, s_word_count}, 32'd4);

        // Asynchronous reset while a write is on the port and another is offered.
        pulse_start();
        in_valid = 1'b1;
        in_op    = 4'd3;
        in_rd    = 5'd1;
        in_rs1   = 5'd0;
        in_rs2   = 5'd0;
        in_imm   = 32'd5;
        @(posedge clk);
        #1;
        check("pre_rst_we", {31'd0, imem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_we", {31'd0, imem_we}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd0);
        check("arst_addr", {24'd0, imem_addr}, 32'd0);
        check("arst_wdata", imem_wdata, 32'd0);
        check("arst_count", {23'd0, word_count}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_no_we", {31'd0, imem_we}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_we", {31'd0, imem_we}, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the core's instruction decoder: takes symbolic instruction fields over a valid/ready handshake and encodes them into RV32I machine words.
- Writes the words sequentially into instruction memory through its write port, for program loading and self-test before the core leaves reset.
- Covers exactly the subset the control path decodes: add, sub, slt, addi, slli, slti, lw, sw, beq, bne, jal. Also accepts an END marker.

Parameters:
- ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a new program load.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder accepts the fields this cycle.
- in_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 ADDI, 4 SLLI, 5 SLTI, 6 LW, 7 SW, 8 BEQ, 9 BNE, 10 JAL, 15 END; other codes are illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  32  signed immediate or byte offset.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  encoded word.
- busy  out  1  load in progress.
- done  out  1  load finished (sticky until start or rst).
- err  out  1  sticky: at least one instruction was dropped.
- word_count  out  ADDR_W+1  words written since start.

Behaviour:
- Reset (async, any state): state IDLE. in_ready, imem_we, busy, done and err are 0. imem_addr = BASE_ADDR. imem_wdata = 0. word_count = 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE --start--> LOAD. Pointer goes to BASE_ADDR; word_count, err and done clear.
  - LOAD --END accepted--> DONE.
  - LOAD --capacity exhausted--> DONE.
  - DONE --start--> LOAD.
- start is honoured in any state. In LOAD it restarts the load: pointer, count and err clear, and any pending write is cancelled.
- busy = (state==LOAD).
- in_ready = (state==LOAD). Fields transfer on the cycle with in_valid & in_ready.
- Latency: a transfer accepted at cycle N produces a single-cycle imem_we at N+1. imem_addr and imem_wdata are registered and stable while imem_we is high. After each write the pointer and word_count increment. Back-to-back transfers give one write per cycle.
- Field packing: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
  - ADD: 0x33, f3 0, f7 0x00.
  - SUB: 0x33, f3 0, f7 0x20.
  - SLT: 0x33, f3 2.
  - ADDI: 0x13, f3 0.
  - SLTI: 0x13, f3 2.
  - SLLI: 0x13, f3 1, [31:25] = 0, shamt [24:20].
  - LW: 0x03, f3 2, I-immediate [31:20].
  - SW: 0x23, f3 2, imm[11:5] at [31:25], imm[4:0] at [11:7].
  - BEQ: 0x63, f3 0.
  - BNE: 0x63, f3 1.
  - B-immediate: imm[12|10:5] at [31:25], imm[4:1|11] at [11:7].
  - JAL: 0x6F, imm[20|10:1|11|19:12] at [31:12].
- Range checks. On failure the instruction is dropped: no write, count unchanged, err set, loading continues.
  - I/S types: -2048..2047.
  - SLLI: 0..31.
  - Branch: -4096..4094, must be even.
  - JAL: -1048576..1048574, must be even.
  - Illegal in_op codes are dropped the same way.
- Fields irrelevant to an op are ignored, e.g. rd for SW/BEQ and rs2 for I-types.
- END writes the halt word 0x0000006F (jal x0,0) at the pointer, then done = 1 at the write cycle.
- Capacity rule:
  - When word_count reaches 2^ADDR_W - 1, only END is written. Any other op is dropped with err, and the FSM stays in LOAD.
  - When word_count reaches 2^ADDR_W, the FSM goes to DONE with err set.
  - The pointer never wraps.
- in_ready is 0 in IDLE and DONE. in_valid there is ignored.

Test Plan:
- ADDI rd1 rs1=0 imm5, then ADD rd3 rs1=1 rs2=2 -> writes 0x00500093 @0 and 0x002081B3 @1 on consecutive cycles, 1 cycle after each accept; word_count=2.
- SUB rd3 rs1=1 rs2=2; LW rd5 rs1=2 imm -4; SW rs1=1 rs2=2 imm 8 -> 0x402081B3, 0xFFC12283, 0x0020A423.
- BEQ rs1=1 rs2=2 imm -8; JAL rd1 imm 16; END -> 0xFE208CE3, 0x010000EF, 0x0000006F. done=1, busy=0, in_ready=0 afterwards.
- ADDI imm 2048, then BEQ imm 3 (odd) -> no imem_we for either, err=1, word_count unchanged. The next valid op is written at the unchanged address.
- ADDR_W=2: four ADDI ops -> three written @0..2, fourth dropped with err. END -> halt word @3, DONE, err=1.
- rst asserted mid-stream with in_valid=1 and a write pending -> outputs go to reset values immediately, no further imem_we. start pulse mid-LOAD -> pointer returns to BASE_ADDR, count and err cleared.
